dmem_access_ctrl: RTL and testbench

- Load/store initiator for the CPU's data RAM port; the MEM stage hands it one memory op at a time.
- Translates MIPS lw/lh/lhu/lb/lbu/sw/sh/sb at byte addresses into word-addressed RAM cycles.
- Sub-word stores use read-modify-write with full-word writes (ram_instr always 0). Loads are extracted and sign- or zero-extended.
- Flags misaligned and out-of-range accesses without touching the RAM.

---
 rtl/dmem_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store initiator for the data RAM port.
// Converts MIPS byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb into word-addressed
// RAM cycles. Sub-word stores use read-modify-write so that every RAM write is
// a full word. Misaligned or out-of-range requests complete with err set and
// never touch the RAM.
module dmem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [1:0]        ram_instr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         lane_q, lane_d;
    logic [ADDR_W-1:0]  widx_q, widx_d;
    logic [31:0]        word_q, word_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        off;
    logic               range_err;
    logic               align_err;
    logic               op_is_load;

    // Replace the addressed lane(s) of the captured word with store data.
    function automatic logic [31:0] merge_word(input logic [2:0]  f_op,
                                               input logic [1:0]  f_lane,
                                               input logic [31:0] f_word,
                                               input logic [31:0] f_wd);
        logic [31:0] m;
        m = f_word;
        case (f_op)
            OP_SW: m = f_wd;
            OP_SH: m = f_lane[1] ? {f_wd[15:0], f_word[15:0]}
                                 : {f_word[31:16], f_wd[15:0]};
            OP_SB: begin
                case (f_lane)
                    2'd0:    m = {f_word[31:8], f_wd[7:0]};
                    2'd1:    m = {f_word[31:16], f_wd[7:0], f_word[7:0]};
                    2'd2:    m = {f_word[31:24], f_wd[7:0], f_word[15:0]};
                    default: m = {f_wd[7:0], f_word[23:0]};
                endcase
            end
            default: m = f_word;
        endcase
        return m;
    endfunction

    // Pick the addressed lane(s) out of a RAM word and sign/zero extend.
    function automatic logic [31:0] load_extract(input logic [2:0]  f_op,
                                                 input logic [1:0]  f_lane,
                                                 input logic [31:0] f_word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [7:0]  byt;
        logic [31:0] r;
        shifted = f_word >> {f_lane, 3'b000};
        half    = shifted[15:0];
        byt     = shifted[7:0];
        case (f_op)
            OP_LH:   r = {{16{half[15]}}, half};
            OP_LHU:  r = {16'h0000, half};
            OP_LB:   r = {{24{byt[7]}}, byt};
            OP_LBU:  r = {24'h000000, byt};
            default: r = f_word;
        endcase
        return r;
    endfunction

    // Request decode: offset into the RAM window and the error conditions.
    always_comb begin
        off       = addr - BASE_ADDR;
        range_err = |off[31:ADDR_W+2];
        align_err = 1'b0;
        case (op)
            OP_LW, OP_SW:         align_err = (off[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: align_err = off[0];
            default:              align_err = 1'b0;
        endcase
    end

    assign op_is_load = (op_q <= OP_LBU);

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        widx_d  = widx_q;
        word_d  = word_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = op;
                    wdata_d = wdata;
                    lane_d  = off[1:0];
                    widx_d  = off[ADDR_W+1:2];
                    if (range_err || align_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (op == OP_SW) ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                word_d = ram_dout;
                // Load result is registered here so it is valid alongside done.
                if (op_is_load) begin
                    rdata_d = load_extract(op_q, lane_q, ram_dout);
                    state_d = S_DONE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            wdata_q <= 32'h0;
            lane_q  <= 2'd0;
            widx_q  <= '0;
            word_q  <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            widx_q  <= widx_d;
            word_q  <= word_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode purely from registered state so reset kills a RAM cycle at once.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) && err_q;
        rdata     = rdata_q;
        ram_ena   = (state_q == S_READ) || (state_q == S_WRITE);
        ram_wena  = (state_q == S_WRITE);
        ram_instr = 2'b00;
        ram_addr  = ram_ena ? widx_q : '0;
        ram_din   = (state_q == S_WRITE) ? merge_word(op_q, lane_q, word_q, wdata_q) : 32'h0;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for dmem_access_ctrl with a behavioural
// word RAM (combinational read, write on rising edge).
module tb_dmem_access_ctrl;

    localparam logic [31:0] BASE   = 32'h10010000;
    localparam int          ADDR_W = 11;

    logic              clk;
    logic              rst;
    logic              req;
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              ram_ena;
    logic              ram_wena;
    logic [1:0]        ram_instr;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    typedef struct {
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_ena;
        int          e_wena;
    } exp_t;

    exp_t sb_q[$];

    int n_checks;
    int n_errors;
    logic [31:0] last_rd;

    dmem_access_ctrl #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ram_ena   (ram_ena),
        .ram_wena  (ram_wena),
        .ram_instr (ram_instr),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, push its expectation, then pop and compare at done.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic x_err, input logic [31:0] x_rd,
                         input int x_lat, input int x_ena, input int x_wena);
        exp_t x;
        int   cyc;
        int   ena;
        int   wena;
        bit   seen;
        x.e_err  = x_err;
        x.e_rd   = x_rd;
        x.e_lat  = x_lat;
        x.e_ena  = x_ena;
        x.e_wena = x_wena;
        @(negedge clk);
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = wd;
        sb_q.push_back(x);
        cyc  = 0;
        ena  = 0;
        wena = 0;
        seen = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            req = 1'b0;
            cyc++;
            if (ram_ena)  ena++;
            if (ram_wena) wena++;
            if (done)     seen = 1;
        end
        x = sb_q.pop_front();
        if (!seen) begin
            chk({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " err"},   {31'd0, err}, {31'd0, x.e_err});
            chk({tag, " rdata"}, rdata, x.e_rd);
            chk({tag, " lat"},   cyc, x.e_lat);
            chk({tag, " ena"},   ena, x.e_ena);
            chk({tag, " wena"},  wena, x.e_wena);
            @(negedge clk);
            chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int dones;
        int enas;
        int dbl;
        logic prev_done;
        exp_t hx;

        n_checks = 0;
        n_errors = 0;
        last_rd  = 32'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[0] = 32'h0BADF00D;
        rst   = 1'b1;
        req   = 1'b0;
        op    = 3'd0;
        addr  = 32'h0;
        wdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy",      {31'd0, busy}, 32'd0);
        chk("rst done",      {31'd0, done}, 32'd0);
        chk("rst err",       {31'd0, err}, 32'd0);
        chk("rst rdata",     rdata, 32'd0);
        chk("rst ram_ena",   {31'd0, ram_ena}, 32'd0);
        chk("rst ram_wena",  {31'd0, ram_wena}, 32'd0);
        chk("rst ram_instr", {30'd0, ram_instr}, 32'd0);
        chk("rst ram_addr",  {21'd0, ram_addr}, 32'd0);
        chk("rst ram_din",   ram_din, 32'd0);
        rst = 1'b0;

        // sw interrupted by reset in its WRITE cycle
        @(negedge clk);
        req = 1'b1; op = 3'd5; addr = BASE; wdata = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b0;
        chk("midw wena_pre",  {31'd0, ram_wena}, 32'd1);
        chk("midw din_pre",   ram_din, 32'hDEADBEEF);
        chk("midw instr_pre", {30'd0, ram_instr}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midw ena",  {31'd0, ram_ena}, 32'd0);
        chk("midw wena", {31'd0, ram_wena}, 32'd0);
        chk("midw busy", {31'd0, busy}, 32'd0);
        chk("midw din",  ram_din, 32'd0);
        @(negedge clk);
        chk("midw mem0", mem[0], 32'h0BADF00D);
        chk("midw done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // round trip
        do_op("sw8", 3'd5, BASE + 8, 32'h80817F01, 1'b0, last_rd, 2, 1, 1);
        chk("sw8 mem2", mem[2], 32'h80817F01);
        do_op("lw8",   3'd0, BASE + 8,  32'h0, 1'b0, 32'h80817F01, 2, 1, 0);
        do_op("lb8",   3'd3, BASE + 8,  32'h0, 1'b0, 32'h00000001, 2, 1, 0);
        do_op("lb9",   3'd3, BASE + 9,  32'h0, 1'b0, 32'h0000007F, 2, 1, 0);
        do_op("lb10",  3'd3, BASE + 10, 32'h0, 1'b0, 32'hFFFFFF81, 2, 1, 0);
        do_op("lbu10", 3'd4, BASE + 10, 32'h0, 1'b0, 32'h00000081, 2, 1, 0);
        do_op("lh10",  3'd1, BASE + 10, 32'h0, 1'b0, 32'hFFFF8081, 2, 1, 0);
        do_op("lhu10", 3'd2, BASE + 10, 32'h0, 1'b0, 32'h00008081, 2, 1, 0);
        last_rd = 32'h00008081;

        // sub-word stores
        do_op("sh10", 3'd6, BASE + 10, 32'h00001234, 1'b0, last_rd, 3, 2, 1);
        chk("sh10 mem2", mem[2], 32'h12347F01);
        do_op("sb8", 3'd7, BASE + 8, 32'h000000AA, 1'b0, last_rd, 3, 2, 1);
        chk("sb8 mem2", mem[2], 32'h12347FAA);

        // errors
        do_op("e_lw2",   3'd0, BASE + 2,    32'h0, 1'b1, last_rd, 1, 0, 0);
        do_op("e_sh1",   3'd6, BASE + 1,    32'h0, 1'b1, last_rd, 1, 0, 0);
        do_op("e_sw8k",  3'd5, BASE + 8192, 32'h5555AAAA, 1'b1, last_rd, 1, 0, 0);
        do_op("e_lwneg", 3'd0, BASE - 4,    32'h0, 1'b1, last_rd, 1, 0, 0);
        chk("e mem2", mem[2], 32'h12347FAA);

        // req held high across three lw ops
        for (int i = 0; i < 3; i++) begin
            hx.e_err = 1'b0; hx.e_rd = 32'h12347FAA; hx.e_lat = 2; hx.e_ena = 1; hx.e_wena = 0;
            sb_q.push_back(hx);
        end
        @(negedge clk);
        req = 1'b1; op = 3'd0; addr = BASE + 8; wdata = 32'h0;
        dones = 0; enas = 0; dbl = 0; prev_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (ram_ena) enas++;
            if (done && prev_done) dbl++;
            if (done) begin
                dones++;
                if (sb_q.size() > 0) begin
                    hx = sb_q.pop_front();
                    chk("hs rdata", rdata, hx.e_rd);
                    chk("hs err", {31'd0, err}, {31'd0, hx.e_err});
                end
            end
            prev_done = done;
        end
        req = 1'b0;
        chk("hs dones", dones, 32'd3);
        chk("hs reads", enas, 32'd3);
        chk("hs double_done", dbl, 32'd0);
        chk("hs sb_empty", sb_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        chk("hs idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
